// File: rtl/readout_tx_pulse_sequencer_if.sv
// Readout TX sequencer bus: envelope/config writes, trigger and
// the DAC sample stream plus RX integration-window strobes.
interface readout_tx_pulse_sequencer_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int ENV_MEM_ADDR_WIDTH = 8,
  parameter int CFG_DATA_WIDTH     = 16,
  parameter int CFG_ADDR_WIDTH     = 2
);
  logic                          env_wr_en;
  logic [ENV_MEM_ADDR_WIDTH-1:0] env_wr_addr;
  logic [2*DATA_WIDTH-1:0]       env_wr_data;
  logic                          cfg_wr_en;
  logic [CFG_ADDR_WIDTH-1:0]     cfg_wr_addr;
  logic [CFG_DATA_WIDTH-1:0]     cfg_wr_data;
  logic                          meas_trigger;
  logic                          busy;
  logic                          valid_out;
  logic [DATA_WIDTH-1:0]         i_out;
  logic [DATA_WIDTH-1:0]         q_out;
  logic                          start_count;
  logic                          finish_count;
  logic                          done;

  modport master (
    output env_wr_en, env_wr_addr, env_wr_data,
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
    output meas_trigger,
    input  busy, valid_out, i_out, q_out,
    input  start_count, finish_count, done
  );

  modport slave (
    input  env_wr_en, env_wr_addr, env_wr_data,
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
    input  meas_trigger,
    output busy, valid_out, i_out, q_out,
    output start_count, finish_count, done
  );
endinterface

// File: rtl/readout_tx_pulse_sequencer.sv
// Readout TX pulse sequencer: plays the I/Q envelope and frames the
// RX integration window. Option: READOUT_TX_AMP_SCALE_EN (amp scaling).
module readout_tx_pulse_sequencer #(
  parameter int DATA_WIDTH         = 16,
  parameter int ENV_MEM_NUM_ENTRY  = 256,
  parameter int ENV_MEM_ADDR_WIDTH = 8,
  parameter int CFG_DATA_WIDTH     = 16,
  parameter int CFG_ADDR_WIDTH     = 2
) (
  input logic clk,
  input logic rst_n,
  readout_tx_pulse_sequencer_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ENV_MEM_ADDR_WIDTH;
  localparam int CW = CFG_DATA_WIDTH;
  localparam int PW = AW + 1;
  localparam int NW = CW + 1;
`ifdef READOUT_TX_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [CW-1:0] NUM_C = CW'(ENV_MEM_NUM_ENTRY);

  typedef enum logic {TX_IDLE, TX_PLAY} tx_st_t;
  typedef enum logic [1:0] {
    CAP_IDLE, CAP_WAIT, CAP_INTEG
  } cap_st_t;

  tx_st_t  tx_st, tx_nx;
  cap_st_t cap_st, cap_nx;

  logic [CW-1:0]   cfg_plen, cfg_cdly, cfg_ilen;
  logic [PW-1:0]   w_plen;
  logic [CW-1:0]   w_ilen;
  logic [AW-1:0]   rd_idx, idx_nx;
  logic [NW-1:0]   cnt, cnt_nx;
  logic            busy_q, busy_nx;
  logic            start_q, start_nx;
  logic            finish_q, finish_nx;
  logic            done_q, done_nx;
  logic            accept, pipe_busy;
  logic [PW-1:0]   p_clamp;
  logic [CW-1:0]   il_fix;

  logic [2*DW-1:0] env_mem [ENV_MEM_NUM_ENTRY];
  logic [2*DW-1:0] rd_data;
  logic            vld1;
  logic            src_v;
  logic [DW-1:0]   src_i, src_q;
  logic            vout;
  logic [DW-1:0]   iout, qout;

`ifdef READOUT_TX_AMP_SCALE_EN
  localparam int MW = DW + CW;
  localparam logic signed [MW-1:0] SMAX =
    {{(MW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN =
    {{(MW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [CW-1:0] cfg_amp, w_amp;
  logic          vld2;
  logic [DW-1:0] i2, q2;

  function automatic logic [DW-1:0] amp_mul(
    input logic [DW-1:0] x,
    input logic [CW-1:0] a
  );
    logic signed [MW-1:0] p;
    p = $signed({{CW{x[DW-1]}}, x}) *
        $signed({{DW{a[CW-1]}}, a});
    p = p >>> (DW - 1);
    if (p > SMAX) return SMAX[DW-1:0];
    if (p < SMIN) return SMIN[DW-1:0];
    return p[DW-1:0];
  endfunction
`endif

  assign accept  = bus.meas_trigger && !busy_q;
  assign p_clamp = (cfg_plen > NUM_C) ?
                   PW'(ENV_MEM_NUM_ENTRY) : cfg_plen[PW-1:0];
  assign il_fix  = (cfg_ilen == '0) ? CW'(1) : cfg_ilen;
`ifdef READOUT_TX_AMP_SCALE_EN
  assign pipe_busy = vld1 | vld2;
`else
  assign pipe_busy = vld1;
`endif

  // envelope RAM, read-before-write on address collision
  always_ff @(posedge clk) begin
    if (bus.env_wr_en) env_mem[bus.env_wr_addr] <= bus.env_wr_data;
    rd_data <= env_mem[rd_idx];
  end

  // config register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_plen <= '0;
      cfg_cdly <= '0;
      cfg_ilen <= CW'(1);
`ifdef READOUT_TX_AMP_SCALE_EN
      cfg_amp  <= {1'b0, {(CW-1){1'b1}}};
`endif
    end else if (bus.cfg_wr_en) begin
      case (bus.cfg_wr_addr)
        CFG_ADDR_WIDTH'(0): cfg_plen <= bus.cfg_wr_data;
        CFG_ADDR_WIDTH'(1): cfg_cdly <= bus.cfg_wr_data;
        CFG_ADDR_WIDTH'(2): cfg_ilen <= bus.cfg_wr_data;
`ifdef READOUT_TX_AMP_SCALE_EN
        CFG_ADDR_WIDTH'(3): cfg_amp  <= bus.cfg_wr_data;
`endif
        default: ;
      endcase
    end
  end

  // working copies frozen at trigger acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_plen <= '0;
      w_ilen <= CW'(1);
`ifdef READOUT_TX_AMP_SCALE_EN
      w_amp  <= '0;
`endif
    end else if (accept) begin
      w_plen <= p_clamp;
      w_ilen <= il_fix;
`ifdef READOUT_TX_AMP_SCALE_EN
      w_amp  <= cfg_amp;
`endif
    end
  end

  // TX/CAP next-state, strobes and completion
  always_comb begin
    tx_nx     = tx_st;
    idx_nx    = rd_idx;
    cap_nx    = cap_st;
    cnt_nx    = cnt;
    busy_nx   = busy_q;
    start_nx  = 1'b0;
    finish_nx = 1'b0;
    done_nx   = 1'b0;
    if (accept) begin
      busy_nx = 1'b1;
      idx_nx  = '0;
      tx_nx   = (p_clamp != '0) ? TX_PLAY : TX_IDLE;
      cap_nx  = CAP_WAIT;
      cnt_nx  = {1'b0, cfg_cdly} + NW'(LAT - 1);
    end else if (busy_q) begin
      unique case (tx_st)
        TX_PLAY: begin
          if ({1'b0, rd_idx} == w_plen - PW'(1)) tx_nx = TX_IDLE;
          else idx_nx = rd_idx + AW'(1);
        end
        TX_IDLE: ;
      endcase
      unique case (cap_st)
        CAP_WAIT: begin
          if (cnt == '0) begin
            start_nx = 1'b1;
            cap_nx   = CAP_INTEG;
            cnt_nx   = {1'b0, w_ilen} - NW'(1);
          end else begin
            cnt_nx = cnt - NW'(1);
          end
        end
        CAP_INTEG: begin
          if (cnt == '0) begin
            finish_nx = 1'b1;
            cap_nx    = CAP_IDLE;
          end else begin
            cnt_nx = cnt - NW'(1);
          end
        end
        default: ;
      endcase
      if (tx_st == TX_IDLE && !pipe_busy && cap_st == CAP_IDLE) begin
        done_nx = 1'b1;
        busy_nx = 1'b0;
      end
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st    <= TX_IDLE;
      cap_st   <= CAP_IDLE;
      rd_idx   <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tx_st    <= tx_nx;
      cap_st   <= cap_nx;
      rd_idx   <= idx_nx;
      cnt      <= cnt_nx;
      busy_q   <= busy_nx;
      start_q  <= start_nx;
      finish_q <= finish_nx;
      done_q   <= done_nx;
    end
  end

`ifdef READOUT_TX_AMP_SCALE_EN
  // read-valid tag and amplitude-scaling stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1 <= 1'b0;
      vld2 <= 1'b0;
      i2   <= '0;
      q2   <= '0;
    end else begin
      vld1 <= (tx_st == TX_PLAY);
      vld2 <= vld1;
      i2   <= amp_mul(rd_data[DW-1:0], w_amp);
      q2   <= amp_mul(rd_data[2*DW-1:DW], w_amp);
    end
  end

  assign src_v = vld2;
  assign src_i = i2;
  assign src_q = q2;
`else
  // read-valid tag for the RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld1 <= 1'b0;
    else        vld1 <= (tx_st == TX_PLAY);
  end

  assign src_v = vld1;
  assign src_i = rd_data[DW-1:0];
  assign src_q = rd_data[2*DW-1:DW];
`endif

  // DAC output register, zeroed between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout <= 1'b0;
      iout <= '0;
      qout <= '0;
    end else begin
      vout <= src_v;
      iout <= src_v ? src_i : '0;
      qout <= src_v ? src_q : '0;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.valid_out    = vout;
  assign bus.i_out        = iout;
  assign bus.q_out        = qout;
  assign bus.start_count  = start_q;
  assign bus.finish_count = finish_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_readout_tx_pulse_sequencer.sv
// Directed bench for readout_tx_pulse_sequencer.
// Expected timing and samples are derived from trigger-relative rules.
module tb_readout_tx_pulse_sequencer;

`ifdef READOUT_TX_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] tb_i [256];
  logic [15:0] tb_q [256];
  logic [15:0] cur_amp = 16'h7FFF;
  logic [15:0] first_i;

  readout_tx_pulse_sequencer_if bus ();

  readout_tx_pulse_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] scale_ref(input logic [15:0] x,
                                            input logic [15:0] a);
    longint p;
    p = longint'($signed(x)) * longint'($signed(a));
    p = p >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [15:0] ref_out(input logic [15:0] x);
`ifdef READOUT_TX_AMP_SCALE_EN
    return scale_ref(x, cur_amp);
`else
    return x;
`endif
  endfunction

  task automatic wcfg(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = a;
    bus.cfg_wr_data = d;
    tick();
    bus.cfg_wr_en = 1'b0;
    if (a == 2'd3) cur_amp = d;
  endtask

  task automatic wenv(input int k);
    bus.env_wr_en   = 1'b1;
    bus.env_wr_addr = 8'(k);
    bus.env_wr_data = {tb_q[k], tb_i[k]};
    tick();
    bus.env_wr_en = 1'b0;
  endtask

  task automatic run(input string tag, input int p, input int cd,
                     input int il, input int n, input int retrig,
                     input int cfgk);
    int ile, st, fi, lv, dn;
    logic ev;
    logic [15:0] ei, eq;
    ile = (il == 0) ? 1 : il;
    st  = LAT + cd;
    fi  = st + ile;
    lv  = LAT + p - 1;
    dn  = ((p > 0 && lv > fi) ? lv : fi) + 1;
    bus.meas_trigger = 1'b1;
    tick();
    bus.meas_trigger = 1'b0;
    for (int k = 0; k < n; k++) begin
      ev = (k >= LAT) && (k < LAT + p);
      chk($sformatf("%s/ctl@%0d", tag, k),
          64'({bus.valid_out, bus.start_count, bus.finish_count,
               bus.done, bus.busy}),
          64'({ev, k == st, k == fi, k == dn, k < dn}));
      ei = '0;
      eq = '0;
      if (ev) begin
        ei = ref_out(tb_i[k-LAT]);
        eq = ref_out(tb_q[k-LAT]);
      end
      chk($sformatf("%s/iq@%0d", tag, k),
          64'({bus.i_out, bus.q_out}), 64'({ei, eq}));
      if (ev && k == LAT) first_i = bus.i_out;
      bus.meas_trigger = (k + 1 == retrig);
      if (k == cfgk) begin
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 2'd0;
        bus.cfg_wr_data = 16'd2;
      end
      tick();
      bus.meas_trigger = 1'b0;
      bus.cfg_wr_en    = 1'b0;
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.valid_out, bus.i_out, bus.q_out, bus.start_count,
                bus.finish_count, bus.done, bus.busy});
  endfunction

  initial begin
    bus.env_wr_en    = 1'b0;
    bus.env_wr_addr  = '0;
    bus.env_wr_data  = '0;
    bus.cfg_wr_en    = 1'b0;
    bus.cfg_wr_addr  = '0;
    bus.cfg_wr_data  = '0;
    bus.meas_trigger = 1'b0;
    repeat (3) tick();
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 256; k++) begin
      tb_i[k] = 16'(k);
      tb_q[k] = 16'(-k);
      wenv(k);
    end

    run("defaults", 0, 0, 1, 6, -1, -1);

    wcfg(2'd0, 16'd4);
    wcfg(2'd2, 16'd3);
    run("t1", 4, 0, 3, 9, -1, -1);

    wcfg(2'd0, 16'd0);
    wcfg(2'd1, 16'd5);
    wcfg(2'd2, 16'd2);
    run("t2", 0, 5, 2, 12, -1, -1);

    wcfg(2'd0, 16'd4);
    wcfg(2'd1, 16'd0);
    wcfg(2'd2, 16'd3);
    run("t3_retrig", 4, 0, 3, 9, 2, -1);
    run("t3_next", 4, 0, 3, 9, -1, -1);

    wcfg(2'd0, 16'd2);
    wcfg(2'd1, 16'd1);
    wcfg(2'd2, 16'd0);
    run("il0", 2, 1, 0, 8, -1, -1);

    wcfg(2'd0, 16'd300);
    wcfg(2'd1, 16'd0);
    wcfg(2'd2, 16'd3);
    run("t4_long", 256, 0, 3, LAT + 260, -1, 10);
    run("t4_after", 2, 0, 3, 9, -1, -1);

    wcfg(2'd0, 16'd4);
    bus.meas_trigger = 1'b1;
    tick();
    bus.meas_trigger = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", 64'(bus.valid_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", outs(), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cur_amp = 16'h7FFF;
    wcfg(2'd0, 16'd4);
    wcfg(2'd2, 16'd3);
    run("t5_repeat", 4, 0, 3, 9, -1, -1);

`ifdef READOUT_TX_AMP_SCALE_EN
    tb_i[0] = 16'h7FFE;
    tb_q[0] = 16'h0000;
    wenv(0);
    wcfg(2'd0, 16'd1);
    wcfg(2'd3, 16'h4000);
    run("amp_half", 1, 0, 1, 7, -1, -1);
    chk("amp_half_i", 64'(first_i), 64'h3FFF);
    tb_i[0] = 16'h8000;
    wenv(0);
    wcfg(2'd3, 16'h8000);
    run("amp_sat", 1, 0, 1, 7, -1, -1);
    chk("amp_sat_i", 64'(first_i), 64'h7FFF);
`else
    wcfg(2'd3, 16'h0001);
    run("amp_ign", 4, 0, 3, 9, -1, -1);
    chk("amp_ign_i", 64'(first_i), 64'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
